// File: rtl/prince_sbox_layer_ctrl.sv
// Sequencer for one PRINCE inverse S-box layer over a 3-share 64-bit state.
// Feeds NUM_SBOX external masked S-box lanes per batch and reassembles the result shares.
module prince_sbox_layer_ctrl #(
  parameter int NUM_SBOX = 4,
  parameter int RND_W    = 108
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [63:0]               in1,
  input  logic [63:0]               in2,
  input  logic [63:0]               in3,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               out1,
  output logic [63:0]               out2,
  output logic [63:0]               out3,
  output logic                      rnd_req,
  input  logic                      rnd_valid,
  input  logic [RND_W*NUM_SBOX-1:0] rnd_data,
  output logic [4*NUM_SBOX-1:0]     sb_in1,
  output logic [4*NUM_SBOX-1:0]     sb_in2,
  output logic [4*NUM_SBOX-1:0]     sb_in3,
  output logic [RND_W*NUM_SBOX-1:0] sb_r,
  output logic [8*NUM_SBOX-1:0]     sb_nbr,
  input  logic [4*NUM_SBOX-1:0]     sb_out1,
  input  logic [4*NUM_SBOX-1:0]     sb_out2,
  input  logic [4*NUM_SBOX-1:0]     sb_out3
);
  localparam int NB = 16 / NUM_SBOX;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [63:0]   buf1_r;
  logic [63:0]   buf2_r;
  logic [63:0]   buf3_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] batch_d_r;
  logic          issue_d_r;
  logic          issue_s;

  // Nibble index handled by lane k in batch b.
  function automatic int nib_pos(input logic [CW-1:0] b, input int k);
    return int'(b) * NUM_SBOX + k;
  endfunction

  assign issue_s = (state_r == FEED) && rnd_valid;

  // Lane routing; every S-box wire stays zero unless a batch is issued this cycle.
  always_comb begin
    sb_in1 = '0;
    sb_in2 = '0;
    sb_in3 = '0;
    sb_r   = '0;
    sb_nbr = '0;
    if (issue_s) begin
      sb_r = rnd_data;
      for (int k = 0; k < NUM_SBOX; k++) begin
        sb_in1[4*k +: 4] = buf1_r[4*nib_pos(cnt_r, k) +: 4];
        sb_in2[4*k +: 4] = buf2_r[4*nib_pos(cnt_r, k) +: 4];
        sb_in3[4*k +: 4] = buf3_r[4*nib_pos(cnt_r, k) +: 4];
        sb_nbr[8*k +: 8] = {buf2_r[4*((nib_pos(cnt_r, k) + 1) & 15) +: 4],
                            buf1_r[4*((nib_pos(cnt_r, k) + 1) & 15) +: 4]};
      end
    end else begin
      sb_in1 = '0;
      sb_in2 = '0;
      sb_in3 = '0;
      sb_r   = '0;
      sb_nbr = '0;
    end
  end

  // Control FSM, batch counter and result capture one cycle after each issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rnd_req   <= 1'b0;
      out1      <= 64'h0;
      out2      <= 64'h0;
      out3      <= 64'h0;
      buf1_r    <= 64'h0;
      buf2_r    <= 64'h0;
      buf3_r    <= 64'h0;
      cnt_r     <= '0;
      batch_d_r <= '0;
      issue_d_r <= 1'b0;
    end else begin
      done      <= 1'b0;
      issue_d_r <= issue_s;
      batch_d_r <= cnt_r;
      if (issue_d_r) begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          out1[4*nib_pos(batch_d_r, k) +: 4] <= sb_out1[4*k +: 4];
          out2[4*nib_pos(batch_d_r, k) +: 4] <= sb_out2[4*k +: 4];
          out3[4*nib_pos(batch_d_r, k) +: 4] <= sb_out3[4*k +: 4];
        end
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            buf1_r  <= in1;
            buf2_r  <= in2;
            buf3_r  <= in3;
            cnt_r   <= '0;
            busy    <= 1'b1;
            rnd_req <= 1'b1;
            state_r <= FEED;
          end
        end
        FEED: begin
          if (rnd_valid) begin
            if (cnt_r == LAST) begin
              rnd_req <= 1'b0;
              state_r <= DRAIN;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        DRAIN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          rnd_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Directed self-checking bench for prince_sbox_layer_ctrl with a behavioural
// masked inverse S-box model on every lane.
module tb_prince_sbox_layer_ctrl;
  localparam int NS = 4;
  localparam int RW = 108;
  localparam int W  = RW * NS;
  localparam int NB = 16 / NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [63:0] in1 = 64'h0, in2 = 64'h0, in3 = 64'h0;
  logic busy, done, rnd_req;
  logic [63:0] out1, out2, out3;
  logic rnd_valid = 1'b0;
  logic [W-1:0] rnd_data = '0;
  logic [4*NS-1:0] sb_in1, sb_in2, sb_in3;
  logic [W-1:0] sb_r;
  logic [8*NS-1:0] sb_nbr;
  logic [4*NS-1:0] sb_out1, sb_out2, sb_out3;

  int n_chk = 0;
  int n_bad = 0;
  logic [8*NS-1:0] nbr_log [0:NB-1];

  always #5 clk = ~clk;

  prince_sbox_layer_ctrl #(.NUM_SBOX(NS), .RND_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .in3(in3),
    .busy(busy), .done(done),
    .out1(out1), .out2(out2), .out3(out3),
    .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
    .sb_r(sb_r), .sb_nbr(sb_nbr),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
  );

  function automatic logic [3:0] invs(input logic [3:0] x);
    case (x)
      4'h0: return 4'hB;  4'h1: return 4'h7;  4'h2: return 4'h3;  4'h3: return 4'h2;
      4'h4: return 4'hF;  4'h5: return 4'hD;  4'h6: return 4'h8;  4'h7: return 4'h9;
      4'h8: return 4'hA;  4'h9: return 4'h6;  4'hA: return 4'h4;  4'hB: return 4'h0;
      4'hC: return 4'h5;  4'hD: return 4'hE;  4'hE: return 4'hC;  default: return 4'h1;
    endcase
  endfunction

  function automatic logic [63:0] inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = invs(x[4*i +: 4]);
    return y;
  endfunction

  // Share-preserving lane model: masks mix randomness and neighbour shares.
  function automatic logic [12*NS-1:0] sbox_model(input logic [4*NS-1:0] i1, i2, i3,
                                                  input logic [W-1:0] r,
                                                  input logic [8*NS-1:0] nb);
    logic [4*NS-1:0] o1, o2, o3;
    logic [3:0] m2, m3;
    for (int k = 0; k < NS; k++) begin
      m2 = r[RW*k +: 4] ^ nb[8*k +: 4];
      m3 = r[RW*k+4 +: 4] ^ nb[8*k+4 +: 4];
      o1[4*k +: 4] = invs(i1[4*k +: 4] ^ i2[4*k +: 4] ^ i3[4*k +: 4]) ^ m2 ^ m3;
      o2[4*k +: 4] = m2;
      o3[4*k +: 4] = m3;
    end
    return {o1, o2, o3};
  endfunction

  always @(posedge clk) {sb_out1, sb_out2, sb_out3} <= sbox_model(sb_in1, sb_in2, sb_in3, sb_r, sb_nbr);

  function automatic logic [W-1:0] rand_rnd();
    logic [447:0] t;
    for (int i = 0; i < 14; i++) t[32*i +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One layer; vpat bit c is rnd_valid in cycle c after start acceptance.
  task automatic run_layer(input logic [63:0] a, b, c, input logic [63:0] vpat, output int dcyc);
    int fed, stalls, hs, n, m;
    logic [4*NS-1:0] e1, e2, e3;
    logic [8*NS-1:0] en;
    in1 = a; in2 = b; in3 = c; start = 1'b1; rnd_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    fed = 0; stalls = 0; hs = 0; dcyc = 0;
    chk("busy_after_start", busy, 1'b1);
    for (int cyc = 1; cyc < 64 && dcyc == 0; cyc++) begin
      rnd_valid = vpat[cyc];
      rnd_data = rand_rnd();
      #1;
      chk("rnd_req", rnd_req, fed < NB);
      if (rnd_req && rnd_valid) hs++;
      if (fed < NB && rnd_valid) begin
        for (int k = 0; k < NS; k++) begin
          n = fed * NS + k;
          m = (n + 1) % 16;
          e1[4*k +: 4] = a[4*n +: 4];
          e2[4*k +: 4] = b[4*n +: 4];
          e3[4*k +: 4] = c[4*n +: 4];
          en[8*k +: 8] = {b[4*m +: 4], a[4*m +: 4]};
        end
        chk("sb_in", {sb_in1, sb_in2, sb_in3}, {e1, e2, e3});
        chk("sb_nbr", sb_nbr, en);
        chk("sb_r", sb_r, rnd_data);
        nbr_log[fed] = sb_nbr;
        fed++;
      end else begin
        if (fed < NB) stalls++;
        chk("sb_quiet", {sb_in1, sb_in2, sb_in3, sb_nbr}, 80'h0);
        chk("sb_r_quiet", sb_r, 1'b0);
      end
      if (done) begin
        dcyc = cyc;
        chk("busy_at_done", busy, 1'b0);
      end
      @(posedge clk); #1;
    end
    rnd_valid = 1'b0;
    chk("done_cycle", dcyc, NB + 2 + stalls);
    chk("handshakes", hs, NB);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d, seen;
    logic [63:0] a, b, c, vp;

    // Reset then idle, with rnd_valid high to confirm IDLE keeps the wires clean.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_valid = 1'b1;
      rnd_data = rand_rnd();
      #1;
      chk("rst_ctrl", {busy, done, rnd_req}, 3'b000);
      chk("rst_out", {out1, out2, out3}, 192'h0);
      chk("rst_sb", {sb_in1, sb_in2, sb_in3, sb_nbr, sb_r}, 512'h0);
      @(posedge clk); #1;
    end
    rnd_valid = 1'b0;

    // Known unmasked vector.
    run_layer(64'h0123456789ABCDEF, 64'h0, 64'h0, {64{1'b1}}, d);
    chk("known_vec", out1 ^ out2 ^ out3, 64'hB732FD89A6405EC1);
    chk("known_lat", d, 6);

    // Stall of three cycles after batch 1.
    run_layer(64'hFEDCBA9876543210, 64'h5A5A5A5A0F0F0F0F, 64'h3C3C3C3CC3C3C3C3, ~64'h38, d);
    chk("stall_lat", d, 9);
    chk("stall_vec", out1 ^ out2 ^ out3,
        inv_layer(64'hFEDCBA9876543210 ^ 64'h5A5A5A5A0F0F0F0F ^ 64'h3C3C3C3CC3C3C3C3));

    // Neighbour mapping, including the wrap from nibble 15 to nibble 0.
    run_layer(64'h0000000000000010, 64'h0000000000000007, 64'h0, {64{1'b1}}, d);
    chk("nbr_nib0", nbr_log[0][7:0], 8'h01);
    chk("nbr_nib15", nbr_log[NB-1][8*NS-1 -: 8], 8'h70);

    // Random masked layers with random rnd_valid gaps.
    for (int t = 0; t < 1000; t++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      for (int i = 0; i < 64; i++) vp[i] = (i > 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
      run_layer(a, b, c, vp, d);
      chk("rand_vec", out1 ^ out2 ^ out3, inv_layer(a ^ b ^ c));
    end

    // start held through busy and DONE; in1 changes after acceptance.
    a = 64'h1122334455667788;
    c = 64'h99AABBCCDDEEFF00;
    in1 = a; in2 = 64'h0; in3 = 64'h0; start = 1'b1; rnd_valid = 1'b1;
    @(posedge clk); #1;
    in1 = c;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      rnd_data = rand_rnd();
      #1;
      chk("hold_busy", busy, cyc < 6);
      chk("hold_done", done, cyc == 6);
      @(posedge clk); #1;
    end
    chk("idle_after_done", {busy, done, rnd_req}, 3'b000);
    chk("hold_vec", out1 ^ out2 ^ out3, inv_layer(a));
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      rnd_data = rand_rnd();
      #1;
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("restart_done", seen, 1);
    chk("restart_vec", out1 ^ out2 ^ out3, inv_layer(c));
    rnd_valid = 1'b0;

    // Reset in the middle of FEED.
    in1 = 64'hA5A5A5A5A5A5A5A5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rnd_valid = 1'b1;
    rnd_data = rand_rnd();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ctrl", {busy, done, rnd_req}, 3'b000);
    chk("midrst_out", {out1, out2, out3}, 192'h0);
    chk("midrst_sb", {sb_in1, sb_in2, sb_in3, sb_nbr, sb_r}, 512'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (done || busy) seen = 1;
      @(posedge clk); #1;
    end
    chk("midrst_quiet", seen, 0);
    rnd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/prince_sbox_layer_ctrl.md
Name: prince_sbox_layer_ctrl

Overview:
Sequencer that runs one full PRINCE inverse S-box layer over a 3-share, 64-bit state. It uses NUM_SBOX external second-order masked inverse S-box instances, each with a one-cycle latency. The block serialises the 16 nibbles into batches and pulls fresh randomness per batch through a valid/request handshake with the PRNG. It also supplies each lane's neighbouring-S-box shares and reassembles the 3-share result. It sits between the round-state register and the S-box instances in the masked PRINCE round datapath.

Parameters:
NUM_SBOX, 4, number of S-box lanes; legal values 1, 2, 4, 8, 16 (must divide 16); NB = 16/NUM_SBOX batches.
RND_W, 108, fresh-mask bits per S-box per cycle.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a layer; sampled only in IDLE
in1, in2, in3  in  64 each  input state shares, sampled on accepted start
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse; out1..3 valid from this cycle onward
out1, out2, out3  out  64 each  result shares; held until next accepted start
rnd_req  out  1  high while in FEED
rnd_valid  in  1  PRNG has RND_W*NUM_SBOX fresh bits
rnd_data  in  RND_W*NUM_SBOX  fresh mask bits
sb_in1, sb_in2, sb_in3  out  4*NUM_SBOX each  S-box input shares, lane k at [4k+3:4k]
sb_r  out  RND_W*NUM_SBOX  S-box randomness, lane k at [RND_W*k+RND_W-1:RND_W*k]
sb_nbr  out  8*NUM_SBOX  neighbour shares, lane k at [8k+7:8k]
sb_out1, sb_out2, sb_out3  in  4*NUM_SBOX each  S-box output shares, valid one cycle after issue

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Reset values: state IDLE; busy 0; done 0; rnd_req 0; out1..3 all-zero; input buffers zero; batch counter 0; issue_d 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - On start, latch in1..3 into internal buffers, clear the counter and go to FEED.
  - start is ignored in every other state.
- FEED, issue condition:
  - rnd_req = 1.
  - An issue occurs in any cycle with rnd_valid = 1. The PRNG treats rnd_valid & rnd_req as consumption.
- FEED, issue behaviour (batch b = counter):
  - Lane k processes nibble n = b*NUM_SBOX + k, i.e. bits [4n+3:4n].
  - sb_in1..3 carry the buffered nibble n of shares 1..3.
  - sb_r = rnd_data, passed straight through.
  - sb_nbr lane k = {share2 nibble m, share1 nibble m}, with m = (n+1) mod 16.
  - Counter increments. Issuing batch NB-1 moves the state to DRAIN.
- FEED, stall (rnd_valid = 0): no issue, the counter holds, and sb_in1..3, sb_r and sb_nbr are driven all-zero.
- Outside any issue cycle, sb_in1..3, sb_r and sb_nbr are driven all-zero (mask hygiene; no stale shares on the wires).
- Capture:
  - issue_d registers the issue flag and the batch index.
  - In the cycle where issue_d = 1, sb_out1..3 are written into out1..3 at the nibbles of the registered batch.
  - Capture continues during FEED stalls and in DRAIN.
- DRAIN: lasts one cycle (the final capture), then goes to DONE.
- DONE: done = 1 for one cycle, busy = 0, then return to IDLE. start in the DONE cycle is ignored.
- Latency: with rnd_valid held high, start is accepted at edge 0 and done is high in cycle NB+2 (6 cycles for NUM_SBOX = 4). Every stall cycle adds exactly one cycle.
- Output updates: out1..3 change only at capture edges and at reset. Partial updates are visible while busy; consumers use done.
- Reset mid-operation: abort immediately to the reset values above. No done pulse; the in-flight S-box result is discarded.
- NUM_SBOX = 16: NB = 1, and FEED lasts until the single issue.

Test Plan:
- Reset then idle:
  - Stimulus: rst for 2 cycles, then start = 0.
  - Required: busy/done/rnd_req = 0, out1..3 = 0, all sb_* outputs = 0 indefinitely.
- Functional, unmasked input:
  - Stimulus: real S-box instances; in1 = 0x0123456789ABCDEF, in2 = in3 = 0; rnd_valid = 1 with random data.
  - Required: out1^out2^out3 = 0xB732FD89A6405EC1; done in cycle 6.
- Functional, random masked input:
  - Stimulus: 1000 random 3-share inputs with random rnd_data and random rnd_valid gaps.
  - Required: the recombined output equals the inverse PRINCE S-box of the recombined input per nibble; done cycle = 6 + number of stall cycles.
- Handshake and randomness routing:
  - Stimulus: rnd_valid low for 3 cycles after batch 1.
  - Required: sb_* outputs all-zero during the stall; the counter is frozen; batch 1 is still captured; exactly NB handshakes per layer; sb_r equals rnd_data bit-exact in issue cycles.
- Neighbour mapping:
  - Stimulus: in1 = 0x0000000000000010, in2 = in3 = 0.
  - Required: the lane processing nibble 0 sees sb_nbr = 0x01; the lane processing nibble 15 sees the nibble-0 shares.
- Protocol corners:
  - Stimulus: start held high through busy, then asserted in the DONE cycle, then asserted again in IDLE.
  - Required: only the last assertion starts a new layer.
  - Stimulus: rst asserted in the middle of FEED.
  - Required: next cycle in IDLE with outputs zeroed and no done pulse.
